// File: rtl/down_counter_timer.sv
// Loadable down counter / programmable timer with a one-cycle terminal-count pulse.
// One-shot or auto-reload operation; all activity on the falling clock edge.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cn_en,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [1:0]       state_reg, state_next;
  logic             tc_reg, tc_next;

  always_comb begin
    q_next      = q_reg;
    reload_next = reload_reg;
    state_next  = state_reg;
    tc_next     = 1'b0;
    if (load) begin
      q_next      = load_val;
      reload_next = load_val;
      state_next  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state_reg == ST_RUN) begin
      if (cn_en) begin
        // RUN always holds q >= 1, so the decrement can never wrap below zero.
        if (q_reg == WIDTH'(1)) begin
          tc_next = 1'b1;
          if (mode) begin
            q_next = reload_reg;
          end else begin
            q_next     = '0;
            state_next = ST_DONE;
          end
        end else begin
          q_next = q_reg - WIDTH'(1);
        end
      end
    end else if (state_reg != ST_IDLE && state_reg != ST_DONE) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      q_reg      <= '0;
      reload_reg <= '0;
      state_reg  <= ST_IDLE;
      tc_reg     <= 1'b0;
    end else begin
      q_reg      <= q_next;
      reload_reg <= reload_next;
      state_reg  <= state_next;
      tc_reg     <= tc_next;
    end
  end

  assign q    = q_reg;
  assign tc   = tc_reg;
  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (WIDTH=4): inputs change just after each falling
// edge and outputs are sampled 1 time unit after the falling edge that consumed them.
module tb_down_counter_timer;

  logic       clk = 1'b1;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       cn_en;
  logic       mode;
  logic [3:0] q;
  logic       tc, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .load(load), .load_val(load_val),
    .cn_en(cn_en), .mode(mode), .q(q), .tc(tc), .busy(busy), .done(done)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got timeout, expected normal finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; load = 1'b0; load_val = 4'd0; cn_en = 1'b0; mode = 1'b0;
    #3;
    vectors++;
    if ({q, tc, busy, done} !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL reset: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
    $display("reset: q=%0d tc=%b busy=%b done=%b", q, tc, busy, done);
    tick();
    clear = 1'b0;
  endtask

  task automatic test_clear_midrun();
    load = 1'b1; load_val = 4'b0110; cn_en = 1'b0; mode = 1'b0;
    tick();
    load = 1'b0;
    vectors++;
    if ({q, busy} !== {4'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL clear_preload: got q=%0d busy=%b, expected q=6 busy=1", q, busy);
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if ({q, tc, busy, done} !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL clear_async: got q=%0d tc=%b busy=%b done=%b, expected all 0",
               q, tc, busy, done);
    end
    $display("clear mid-run: q=%0d tc=%b busy=%b done=%b", q, tc, busy, done);
    #1 clear = 1'b0;
    cn_en = 1'b1;
    tick();
    vectors++;
    if ({q, tc, busy, done} !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL clear_stays_idle: got q=%0d tc=%b busy=%b done=%b, expected all 0",
               q, tc, busy, done);
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q  [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_bz [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    load = 1'b1; load_val = 4'd3; mode = 1'b0; cn_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      vectors++;
      if ({q, tc, busy, done} !== {exp_q[i], exp_tc[i], exp_bz[i], ~exp_bz[i]}) begin
        miscompares++;
        $display("FAIL one_shot[%0d]: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, exp_q[i], exp_tc[i], exp_bz[i], ~exp_bz[i]);
      end
      $display("one_shot edge %0d: q=%0d tc=%b busy=%b done=%b", i, q, tc, busy, done);
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_q  [10] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    logic       exp_tc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_val = 4'd3; mode = 1'b1; cn_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      load = 1'b0;
      vectors++;
      if ({q, tc, busy, done} !== {exp_q[i], exp_tc[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL auto_reload[%0d]: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=1 done=0",
                 i, q, tc, busy, done, exp_q[i], exp_tc[i]);
      end
      $display("auto_reload edge %0d: q=%0d tc=%b", i, q, tc);
    end
    // tc must drop on the next edge even with counting disabled
    cn_en = 1'b0;
    tick();
    vectors++;
    if ({q, tc, busy} !== {4'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL tc_fall_no_en: got q=%0d tc=%b busy=%b, expected q=3 tc=0 busy=1", q, tc, busy);
    end
  endtask

  task automatic test_enable_gating();
    logic [3:0] exp_q [5] = '{4'd5, 4'd4, 4'd4, 4'd3, 4'd3};
    logic       en    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    load = 1'b1; load_val = 4'd5; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cn_en = en[i];
      tick();
      load = 1'b0;
      vectors++;
      if ({q, tc, busy} !== {exp_q[i], 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL enable_gating[%0d]: got q=%0d tc=%b busy=%b, expected q=%0d tc=0 busy=1",
                 i, q, tc, busy, exp_q[i]);
      end
      $display("enable_gating edge %0d: cn_en=%b q=%0d", i, en[i], q);
    end
  endtask

  task automatic test_reload_midrun();
    load = 1'b1; load_val = 4'd3; mode = 1'b0; cn_en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    vectors++;
    if (q !== 4'd2) begin
      miscompares++;
      $display("FAIL reload_setup: got q=%0d, expected q=2", q);
    end
    load = 1'b1; load_val = 4'd9;
    tick();
    vectors++;
    if ({q, tc, busy, done} !== {4'd9, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reload_9: got q=%0d tc=%b busy=%b done=%b, expected q=9 tc=0 busy=1 done=0",
               q, tc, busy, done);
    end
    load_val = 4'd0;
    tick();
    load = 1'b0;
    vectors++;
    if ({q, tc, busy, done} !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL load_zero: got q=%0d tc=%b busy=%b done=%b, expected all 0", q, tc, busy, done);
    end
    tick();
    vectors++;
    if ({q, tc, busy} !== 6'b0000_00) begin
      miscompares++;
      $display("FAIL idle_hold: got q=%0d tc=%b busy=%b, expected q=0 tc=0 busy=0", q, tc, busy);
    end
    $display("reload mid-run: q=%0d busy=%b", q, busy);
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_val = 4'd1; mode = 1'b1; cn_en = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if ({q, tc, busy} !== {4'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_load: got q=%0d tc=%b busy=%b, expected q=1 tc=0 busy=1", q, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({q, tc, busy} !== {4'd1, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL b2b_pulse[%0d]: got q=%0d tc=%b busy=%b, expected q=1 tc=1 busy=1",
                 i, q, tc, busy);
      end
      $display("back_to_back edge %0d: q=%0d tc=%b", i, q, tc);
    end
    mode = 1'b0;
    tick();
    vectors++;
    if ({q, tc, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_expire: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=1 busy=0 done=1",
               q, tc, busy, done);
    end
    tick();
    vectors++;
    if ({q, tc, done} !== {4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_after: got q=%0d tc=%b done=%b, expected q=0 tc=0 done=1", q, tc, done);
    end
  endtask

  task automatic test_clear_over_load();
    load = 1'b1; load_val = 4'd7; cn_en = 1'b0;
    clear = 1'b1;
    tick();
    vectors++;
    if ({q, busy, done} !== 6'b0000_00) begin
      miscompares++;
      $display("FAIL clear_over_load: got q=%0d busy=%b done=%b, expected q=0 busy=0 done=0",
               q, busy, done);
    end
    clear = 1'b0;
    tick();
    load = 1'b0;
    vectors++;
    if ({q, busy} !== {4'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL load_after_clear: got q=%0d busy=%b, expected q=7 busy=1", q, busy);
    end
    $display("clear vs load: q=%0d busy=%b", q, busy);
  endtask

  initial begin
    test_reset();
    test_clear_midrun();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_reload_midrun();
    test_back_to_back();
    test_clear_over_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
